// File: rtl/sensor_frame_packer.sv
// Sensor frame packer: clamps signed samples, packs up to NUM_WORDS of them into a
// frame with a trailing additive checksum, and drops partial frames that stall.
module sensor_frame_packer #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_WORDS      = 15,
  parameter int CHECKSUM_WIDTH = 16,
  parameter int RANGE_LIMIT    = 10000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [DATA_WIDTH-1:0]                         in_word,
  input  logic                                          in_last,
  output logic                                          frame_valid,
  input  logic                                          frame_ready,
  output logic [NUM_WORDS*DATA_WIDTH+CHECKSUM_WIDTH-1:0] frame_out,
  output logic                                          frame_clamped,
  output logic [7:0]                                    drop_count
);

  localparam int IDX_W  = $clog2(NUM_WORDS + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PAY_W  = NUM_WORDS * DATA_WIDTH;

  localparam logic signed [DATA_WIDTH-1:0] POS_LIM  = DATA_WIDTH'(RANGE_LIMIT);
  localparam logic signed [DATA_WIDTH-1:0] NEG_LIM  = DATA_WIDTH'(-RANGE_LIMIT);
  localparam logic        [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic        [IDLE_W-1:0]     IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {COLLECT, EMIT} state_t;

  function automatic logic signed [DATA_WIDTH-1:0] clamp_sample(
    input logic signed [DATA_WIDTH-1:0] x
  );
    if (x > POS_LIM) return POS_LIM;
    if (x < NEG_LIM) return NEG_LIM;
    return x;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  state_t                         state_q, state_d;
  logic        [IDX_W-1:0]        idx_q, idx_d;
  logic        [IDLE_W-1:0]       idle_q, idle_d;
  logic        [CHECKSUM_WIDTH-1:0] sum_q, sum_d;
  logic                           clamped_q, clamped_d;
  logic        [7:0]              drop_q, drop_d;
  logic signed [DATA_WIDTH-1:0]   words_q [NUM_WORDS];
  logic signed [DATA_WIDTH-1:0]   words_d [NUM_WORDS];

  logic                           accept;
  logic signed [DATA_WIDTH-1:0]   c_word;

  assign accept = in_valid && (state_q == COLLECT);
  assign c_word = clamp_sample($signed(in_word));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    idle_d    = idle_q;
    sum_d     = sum_q;
    clamped_d = clamped_q;
    drop_d    = drop_q;
    words_d   = words_q;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          words_d[idx_q] = c_word;
          sum_d          = sum_q + CHECKSUM_WIDTH'($unsigned(c_word));
          clamped_d      = clamped_q | (c_word != $signed(in_word));
          idx_d          = idx_q + IDX_W'(1);
          idle_d         = '0;
          if (idx_q == LAST_IDX || in_last) state_d = EMIT;
        end else if (idx_q != '0) begin
          // A stalled partial frame is discarded once the idle budget runs out.
          if (idle_q == IDLE_MAX) begin
            idx_d     = '0;
            idle_d    = '0;
            sum_d     = '0;
            clamped_d = 1'b0;
            drop_d    = sat_inc8(drop_q);
            for (int i = 0; i < NUM_WORDS; i++) words_d[i] = '0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end else begin
          idle_d = '0;
        end
      end
      EMIT: begin
        idle_d = '0;
        if (frame_ready) begin
          state_d   = COLLECT;
          idx_d     = '0;
          sum_d     = '0;
          clamped_d = 1'b0;
          for (int i = 0; i < NUM_WORDS; i++) words_d[i] = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      idle_q    <= '0;
      sum_q     <= '0;
      clamped_q <= 1'b0;
      drop_q    <= '0;
      for (int i = 0; i < NUM_WORDS; i++) words_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      idle_q    <= idle_d;
      sum_q     <= sum_d;
      clamped_q <= clamped_d;
      drop_q    <= drop_d;
      words_q   <= words_d;
    end
  end

  // Outputs come straight from registers; slots fill in place so padding stays zero.
  always_comb begin
    frame_out = '0;
    for (int i = 0; i < NUM_WORDS; i++) frame_out[i*DATA_WIDTH +: DATA_WIDTH] = words_q[i];
    frame_out[PAY_W +: CHECKSUM_WIDTH] = sum_q;
  end

  assign in_ready      = (state_q == COLLECT);
  assign frame_valid   = (state_q == EMIT);
  assign frame_clamped = clamped_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_sensor_frame_packer.sv
// Directed bench for sensor_frame_packer: clamp vectors as one-word frames plus
// hand-written sequences for full frames, backpressure, timeout, reset and saturation.
module tb_sensor_frame_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_last, frame_ready;
  logic [15:0]  in_word;
  logic         in_ready, frame_valid, frame_clamped;
  logic [255:0] frame_out;
  logic [7:0]   drop_count;

  logic         s_in_valid, s_in_last, s_frame_ready;
  logic [15:0]  s_in_word;
  logic         s_in_ready, s_frame_valid, s_frame_clamped;
  logic [255:0] s_frame_out;
  logic [7:0]   s_drop_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sensor_frame_packer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_out(frame_out),
    .frame_clamped(frame_clamped), .drop_count(drop_count)
  );

  // Short timeout so that 256 drops fit in a modest run.
  sensor_frame_packer #(.TIMEOUT_CYCLES(8)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_word(s_in_word), .in_last(s_in_last),
    .frame_valid(s_frame_valid), .frame_ready(s_frame_ready), .frame_out(s_frame_out),
    .frame_clamped(s_frame_clamped), .drop_count(s_drop_count)
  );

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_word;
    logic        exp_clamped;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w, input logic last);
    in_valid = 1'b1;
    in_word  = w;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  logic [255:0] hold;
  logic [255:0] exp_frame;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{16'h8000, 16'hD8F0, 1'b1};
    vecs[1] = '{16'h7FFF, 16'h2710, 1'b1};
    vecs[2] = '{16'h2710, 16'h2710, 1'b0};
    vecs[3] = '{16'h2711, 16'h2710, 1'b1};
    vecs[4] = '{16'hD8F0, 16'hD8F0, 1'b0};
    vecs[5] = '{16'hD8EF, 16'hD8F0, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_word = '0; frame_ready = 1'b1;
    s_in_valid = 1'b0; s_in_last = 1'b0; s_in_word = '0; s_frame_ready = 1'b1;
    tick();
    tick();
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_frame_out", frame_out, 0);
    chk("rst_clamped", frame_clamped, 0);
    chk("rst_drop", drop_count, 0);
    rst = 1'b0;
    tick();

    // Words 1..15 back-to-back
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) chk("seq_valid_before_close", frame_valid, 0);
      in_valid = 1'b1; in_word = 16'(i); in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    chk("seq_valid", frame_valid, 1);
    chk("seq_word0", frame_out[15:0], 16'h0001);
    chk("seq_word14", frame_out[239:224], 16'h000F);
    chk("seq_checksum", frame_out[255:240], 16'h0078);
    chk("seq_clamped", frame_clamped, 0);
    chk("seq_in_ready", in_ready, 0);
    tick();
    chk("seq_valid_fall", frame_valid, 0);
    chk("seq_in_ready_back", in_ready, 1);

    // Clamped short frame
    send(16'h2EE0, 1'b0);
    send(16'h8000, 1'b1);
    exp_frame = '0;
    exp_frame[15:0]  = 16'h2710;
    exp_frame[31:16] = 16'hD8F0;
    chk("short_valid", frame_valid, 1);
    chk("short_frame", frame_out, exp_frame);
    chk("short_clamped", frame_clamped, 1);
    tick();
    chk("short_valid_fall", frame_valid, 0);

    // One-word frames exercising the clamp boundaries
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].din, 1'b1);
      chk($sformatf("vec%0d_valid", v), frame_valid, 1);
      chk($sformatf("vec%0d_word0", v), frame_out[15:0], vecs[v].exp_word);
      chk($sformatf("vec%0d_checksum", v), frame_out[255:240], vecs[v].exp_word);
      chk($sformatf("vec%0d_pad", v), frame_out[239:16], 0);
      chk($sformatf("vec%0d_clamped", v), frame_clamped, vecs[v].exp_clamped);
      tick();
      chk($sformatf("vec%0d_valid_fall", v), frame_valid, 0);
    end

    // Backpressure with a wrapping checksum: 15 * 10000 mod 65536 = 0x49F0
    frame_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(16'h2710, 1'b0);
    chk("bp_valid", frame_valid, 1);
    chk("bp_checksum", frame_out[255:240], 16'h49F0);
    hold = frame_out;
    in_valid = 1'b1; in_word = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_hold_valid%0d", i), frame_valid, 1);
      chk($sformatf("bp_hold_frame%0d", i), frame_out, hold);
      chk($sformatf("bp_hold_ready%0d", i), in_ready, 0);
    end
    in_valid = 1'b0;
    frame_ready = 1'b1;
    tick();
    chk("bp_release_valid", frame_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_no_sample_taken", frame_out, 0);

    // Reset mid-frame
    for (int i = 0; i < 7; i++) send(16'h0055, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", frame_valid, 0);
    chk("mrst_drop", drop_count, 0);
    chk("mrst_frame", frame_out, 0);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) send(16'h0002, 1'b0);
    chk("mrst_next_valid", frame_valid, 1);
    chk("mrst_next_checksum", frame_out[255:240], 16'h001E);
    chk("mrst_next_word0", frame_out[15:0], 16'h0002);
    tick();

    // Timeout drop
    send(16'h0005, 1'b0);
    send(16'h0006, 1'b0);
    send(16'h0007, 1'b0);
    repeat (1023) tick();
    chk("to_no_drop_yet", drop_count, 0);
    tick();
    chk("to_drop", drop_count, 1);
    chk("to_cleared", frame_out, 0);
    for (int i = 0; i < 15; i++) send(16'(16'h10 + i), 1'b0);
    chk("to_next_valid", frame_valid, 1);
    chk("to_next_word0", frame_out[15:0], 16'h0010);
    chk("to_next_word14", frame_out[239:224], 16'h001E);
    chk("to_next_checksum", frame_out[255:240], 16'h0159);
    tick();

    // One cycle short of timeout, then an accept: no drop, idle counter restarts
    send(16'h0001, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h0001, 1'b0);
    repeat (1023) tick();
    send(16'h0004, 1'b0);
    chk("nd_drop_after_accept", drop_count, 1);
    repeat (1023) tick();
    send(16'h0008, 1'b1);
    chk("nd_drop_final", drop_count, 1);
    chk("nd_valid", frame_valid, 1);
    chk("nd_checksum", frame_out[255:240], 16'h000F);
    chk("nd_word4", frame_out[79:64], 16'h0008);
    tick();

    // Drop counter saturation on the short-timeout instance
    for (int k = 0; k < 258; k++) begin
      s_in_valid = 1'b1; s_in_word = 16'h0001; s_in_last = 1'b0;
      tick();
      s_in_valid = 1'b0;
      repeat (8) tick();
      if (k == 253) chk("sat_254", s_drop_count, 254);
      if (k == 254) chk("sat_255", s_drop_count, 255);
    end
    chk("sat_stays_255", s_drop_count, 255);
    chk("sat_frame_valid", s_frame_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
